// File: rtl/link_arbiter_pkg.sv
// Shared types and constants for the link arbiter and its helpers.
package link_arbiter_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Frame layout: payload first (bit 0 is the first payload bit), CRC last.
  localparam int PAYLOAD_W   = 50;
  localparam int CRC_W       = 16;
  localparam int FRAME_W_DEF = PAYLOAD_W + CRC_W;

  // Largest supported sender count.
  localparam int MAX_SENDERS = 8;

  // Width of a sender index; a single sender still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAX_IDX_W = idx_w(MAX_SENDERS);

endpackage

// File: rtl/link_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo N_SENDERS.
module rr_picker
  import link_arbiter_pkg::*;
#(
  parameter int N_SENDERS = 2,
  parameter int IDX_W     = idx_w(N_SENDERS)
) (
  input  logic [N_SENDERS-1:0] rts,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_req
);

  logic [IDX_W-1:0]     cand_idx [N_SENDERS];
  logic [N_SENDERS-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_SENDERS; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      // Sender reached by stepping gi places past rr_ptr, wrapped into range.
      assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_SENDERS))
                            ? IDX_W'(sum - (IDX_W+1)'(N_SENDERS))
                            : sum[IDX_W-1:0];
      assign cand_req[gi] = rts[cand_idx[gi]];
    end
  endgenerate

  // Smallest offset from rr_ptr with an active request wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = N_SENDERS - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_idx = cand_idx[i];
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// Shares one receiver link between several RTS/CTS senders: grants one
// sender at a time round-robin, captures its frame when RTS falls, and
// presents it to the receiver with NAK-driven resends up to a retry limit.
module link_arbiter
  import link_arbiter_pkg::*;
#(
  parameter  int N_SENDERS     = 2,
  parameter  int FRAME_W       = FRAME_W_DEF,
  parameter  int MAX_RETRY     = 3,
  parameter  int GRANT_TIMEOUT = 255,
  localparam int IDX_W         = idx_w(N_SENDERS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SENDERS-1:0]       rts,
  output logic [N_SENDERS-1:0]       cts,
  input  logic [0:N_SENDERS*FRAME_W-1] frame_in,
  output logic [0:FRAME_W-1]         frame_out,
  output logic                       frame_valid,
  output logic [IDX_W-1:0]           frame_src,
  input  logic                       rx_ack,
  input  logic                       rx_nak,
  output logic                       drop_err,
  output logic                       timeout_err,
  output logic                       busy
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TIMER_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(GRANT_TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_SENDERS - 1);

  arb_state_t           state_reg,   state_next;
  logic [N_SENDERS-1:0] cts_reg,     cts_next;
  logic [0:FRAME_W-1]   frame_reg,   frame_next;
  logic                 valid_reg,   valid_next;
  logic [IDX_W-1:0]     src_reg,     src_next;
  logic [IDX_W-1:0]     rr_ptr_reg,  rr_ptr_next;
  logic [RETRY_W-1:0]   retry_reg,   retry_next;
  logic [TIMER_W-1:0]   timer_reg,   timer_next;
  logic                 drop_reg,    drop_next;
  logic                 timeout_reg, timeout_next;

  logic [IDX_W-1:0]     grant_idx;
  logic                 any_req;

  // Per-sender view of the flat frame bus.
  logic [0:FRAME_W-1]   sender_frame [N_SENDERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_SENDERS; gi++) begin : g_slice
      assign sender_frame[gi] = frame_in[gi*FRAME_W +: FRAME_W];
    end
  endgenerate

  rr_picker #(
    .N_SENDERS (N_SENDERS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .rts       (rts),
    .rr_ptr    (rr_ptr_reg),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // State and datapath registers; reset discards any held frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cts_reg     <= '0;
      frame_reg   <= '0;
      valid_reg   <= 1'b0;
      src_reg     <= '0;
      rr_ptr_reg  <= '0;
      retry_reg   <= '0;
      timer_reg   <= '0;
      drop_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cts_reg     <= cts_next;
      frame_reg   <= frame_next;
      valid_reg   <= valid_next;
      src_reg     <= src_next;
      rr_ptr_reg  <= rr_ptr_next;
      retry_reg   <= retry_next;
      timer_reg   <= timer_next;
      drop_reg    <= drop_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state and next-output logic; error flags are single-cycle pulses.
  always_comb begin
    state_next   = state_reg;
    cts_next     = cts_reg;
    frame_next   = frame_reg;
    valid_next   = valid_reg;
    src_next     = src_reg;
    rr_ptr_next  = rr_ptr_reg;
    retry_next   = retry_reg;
    timer_next   = timer_reg;
    drop_next    = 1'b0;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // Grant is issued from IDLE only, so CTS is always low for at
        // least one cycle between two grants.
        if (any_req) begin
          cts_next            = '0;
          cts_next[grant_idx] = 1'b1;
          src_next            = grant_idx;
          rr_ptr_next         = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          timer_next          = '0;
          state_next          = GRANT;
        end
      end

      GRANT: begin
        // A falling RTS takes priority over a timeout on the same edge.
        if (!rts[src_reg]) begin
          frame_next = sender_frame[src_reg];
          cts_next   = '0;
          valid_next = 1'b1;
          retry_next = '0;
          state_next = SEND;
        end else if (timer_reg == TIMER_LIMIT) begin
          cts_next     = '0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      SEND: begin
        // ACK wins over a simultaneous NAK.
        if (rx_ack) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (rx_nak) begin
          valid_next = 1'b0;
          if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 1'b1;
            state_next = GAP;
          end else begin
            drop_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

      GAP: begin
        // One idle cycle, then resend the unchanged frame.
        valid_next = 1'b1;
        state_next = SEND;
      end

      default: begin
        state_next = IDLE;
        cts_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  assign cts         = cts_reg;
  assign frame_out   = frame_reg;
  assign frame_valid = valid_reg;
  assign drop_err    = drop_reg;
  assign timeout_err = timeout_reg;
  assign busy        = (state_reg != IDLE);

  // A lone sender always owns the link.
  generate
    if (N_SENDERS == 1) begin : g_src_single
      assign frame_src = '0;
    end else begin : g_src_multi
      assign frame_src = src_reg;
    end
  endgenerate

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_link_arbiter;

  localparam int N    = 4;
  localparam int FW   = 66;
  localparam int MAXR = 3;
  localparam int TMO  = 255;
  localparam int IW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    rts;
  logic [N-1:0]    cts;
  logic [0:N*FW-1] frame_in;
  logic [0:FW-1]   frame_out;
  logic            frame_valid;
  logic [IW-1:0]   frame_src;
  logic            rx_ack;
  logic            rx_nak;
  logic            drop_err;
  logic            timeout_err;
  logic            busy;

  logic [0:FW-1]   tx_frame [N];
  int              n_cmp = 0;
  int              n_mis = 0;
  int              ptr_model = 0;

  always #5 clk = ~clk;

  link_arbiter #(
    .N_SENDERS     (N),
    .FRAME_W       (FW),
    .MAX_RETRY     (MAXR),
    .GRANT_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rts         (rts),
    .cts         (cts),
    .frame_in    (frame_in),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_src   (frame_src),
    .rx_ack      (rx_ack),
    .rx_nak      (rx_nak),
    .drop_err    (drop_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_frames();
    for (int i = 0; i < N; i++) frame_in[i*FW +: FW] = tx_frame[i];
  endtask

  task automatic randomize_frames();
    for (int i = 0; i < N; i++) tx_frame[i] = FW'({$urandom(), $urandom(), $urandom()});
  endtask

  // Round-robin rule: first requester at or after ptr, wrapping modulo N.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // One full transaction: grant, hold RTS, capture, n_nak NAKs, then ACK
  // (or a drop once the NAK count exceeds the retry limit).
  task automatic run_frame(input logic [N-1:0] mask, input int hold,
                           input int n_nak, input bit both);
    int            g;
    int            naks;
    int            waits;
    logic [N-1:0]  oh;
    logic [0:FW-1] exp_frame;

    g  = pick(mask, ptr_model);
    oh = N'(1) << g;
    rts = mask;
    drive_frames();
    tick();
    check("grant_cts", cts, oh);
    check("grant_src", frame_src, g);
    check("grant_busy", busy, 1'b1);
    check("grant_valid", frame_valid, 1'b0);
    ptr_model = (g + 1) % N;

    for (int j = 0; j < hold; j++) begin
      rx_ack = 1'($urandom_range(0, 1));
      rx_nak = 1'($urandom_range(0, 1));
      tick();
      check("hold_cts", cts, oh);
      check("hold_valid", frame_valid, 1'b0);
    end
    rts[g] = 1'b0;
    rx_ack = 1'b0;
    rx_nak = 1'b0;
    tick();
    exp_frame = tx_frame[g];
    check("cap_valid", frame_valid, 1'b1);
    check("cap_frame", frame_out, exp_frame);
    check("cap_cts", cts, '0);
    check("cap_src", frame_src, g);

    // Sender frames change after capture; frame_out must not follow.
    randomize_frames();
    drive_frames();
    waits = $urandom_range(0, 2);
    for (int w = 0; w < waits; w++) begin
      tick();
      check("send_valid", frame_valid, 1'b1);
      check("send_frame", frame_out, exp_frame);
    end

    naks = 0;
    for (int r = 0; r < n_nak; r++) begin
      rx_nak = 1'b1;
      if (naks == MAXR) rts = '0;
      tick();
      rx_nak = 1'b0;
      if (naks < MAXR) begin
        naks++;
        check("gap_valid", frame_valid, 1'b0);
        check("gap_drop", drop_err, 1'b0);
        check("gap_busy", busy, 1'b1);
        rx_ack = 1'($urandom_range(0, 1));
        rx_nak = 1'($urandom_range(0, 1));
        tick();
        rx_ack = 1'b0;
        rx_nak = 1'b0;
        check("resend_valid", frame_valid, 1'b1);
        check("resend_frame", frame_out, exp_frame);
      end else begin
        check("drop_pulse", drop_err, 1'b1);
        check("drop_valid", frame_valid, 1'b0);
        check("drop_busy", busy, 1'b0);
        tick();
        check("drop_clear", drop_err, 1'b0);
        check("drop_cts", cts, '0);
        $display("txn: sender=%0d hold=%0d naks=%0d dropped", g, hold, n_nak);
        return;
      end
    end

    rx_ack = 1'b1;
    rx_nak = both ? 1'b1 : 1'($urandom_range(0, 1));
    rts    = '0;
    tick();
    rx_ack = 1'b0;
    rx_nak = 1'b0;
    check("ack_valid", frame_valid, 1'b0);
    check("ack_busy", busy, 1'b0);
    check("ack_drop", drop_err, 1'b0);
    tick();
    check("idle_valid", frame_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    $display("txn: sender=%0d hold=%0d naks=%0d acked both=%0d", g, hold, n_nak, both);
  endtask

  // Grant held open with RTS high until the timeout fires.
  task automatic run_timeout(input logic [N-1:0] mask);
    int           g;
    logic [N-1:0] oh;
    g  = pick(mask, ptr_model);
    oh = N'(1) << g;
    rts = mask;
    drive_frames();
    tick();
    check("tmo_grant", cts, oh);
    ptr_model = (g + 1) % N;
    for (int j = 1; j <= TMO; j++) begin
      tick();
      check("tmo_cts", cts, oh);
      check("tmo_early", timeout_err, 1'b0);
    end
    tick();
    check("tmo_pulse", timeout_err, 1'b1);
    check("tmo_cts_low", cts, '0);
    check("tmo_busy", busy, 1'b0);
    rts = '0;
    tick();
    check("tmo_clear", timeout_err, 1'b0);
    $display("txn: sender=%0d timed out", g);
  endtask

  initial begin
    rst_n  = 1'b0;
    rts    = '0;
    rx_ack = 1'b0;
    rx_nak = 1'b0;
    randomize_frames();
    drive_frames();
    @(negedge clk);
    tick();
    check("rst_cts", cts, '0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_frame", frame_out, '0);
    check("rst_src", frame_src, '0);
    check("rst_drop", drop_err, 1'b0);
    check("rst_tmo", timeout_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Two senders requesting continuously: grants alternate 0,1,0,1.
    tx_frame[0] = {50'h3_0000_0000_00FF, 16'hA5C3};
    tx_frame[1] = {50'h1_2345_6789_ABCD, 16'h5A3C};
    for (int i = 0; i < 4; i++) begin
      tx_frame[0] = {50'h3_0000_0000_00FF, 16'hA5C3};
      run_frame(4'b0011, 5, 0, 1'b0);
    end

    // Single NAK then ACK; four NAKs to drop; ACK and NAK together.
    run_frame(4'b0011, 5, 1, 1'b0);
    run_frame(4'b0011, 3, 4, 1'b0);
    run_frame(4'b0011, 2, 0, 1'b1);

    // Timeout, then the other sender is granted next.
    run_timeout(4'b0011);
    run_frame(4'b0011, 2, 0, 1'b0);

    // RTS falls on the very edge the timeout would fire: capture wins.
    run_frame(4'b0001, TMO, 0, 1'b0);

    // Reset while a frame is being presented.
    rts = 4'b0001;
    drive_frames();
    tick();
    rts = '0;
    tick();
    check("pre_rst_valid", frame_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cts", cts, '0);
    check("mid_rst_valid", frame_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_frame", frame_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_model = 0;
    $display("txn: reset during send");
    run_frame(4'b0011, 1, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      randomize_frames();
      run_frame(N'($urandom_range(1, 15)), $urandom_range(0, 8),
                $urandom_range(0, MAXR + 1), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
